// File: rtl/btn_pkg.sv
// -----------------------------------------------------------------------------
// btn_pkg
// Shared definitions for the button pulse generator.
//   lane_state_t       : per-lane state encoding (WAIT_REL, IDLE, HOLD, REPEAT)
//   DEF_HOLD_CYCLES    : default press-to-first-repeat delay at 100 MHz (0.5 s)
//   DEF_REPEAT_CYCLES  : default repeat period at 100 MHz (0.1 s)
// -----------------------------------------------------------------------------
package btn_pkg;

    typedef enum logic [1:0] {
        WAIT_REL = 2'd0,
        IDLE     = 2'd1,
        HOLD     = 2'd2,
        REPEAT   = 2'd3
    } lane_state_t;

    localparam int DEF_HOLD_CYCLES   = 50_000_000;
    localparam int DEF_REPEAT_CYCLES = 10_000_000;

endpackage : btn_pkg

// File: rtl/btn_pulse_lane.sv
// -----------------------------------------------------------------------------
// btn_pulse_lane
// One button lane: turns a debounced level into a single press pulse, then
// auto-repeat pulses while the button stays held.
// Ports:
//   clk        in  system clock
//   rst_n      in  asynchronous active-low reset
//   btn_lvl    in  debounced button level (synchronous to clk)
//   repeat_en  in  auto-repeat enable, sampled every cycle
//   pulse      out registered one-cycle press/repeat pulse
//   held       out registered, high while the lane is in HOLD or REPEAT
// The lane state register is named `state` for hierarchical observation.
// -----------------------------------------------------------------------------
module btn_pulse_lane
    import btn_pkg::*;
#(
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_lvl,
    input  logic repeat_en,
    output logic pulse,
    output logic held
);

    localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX);

    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CYCLES - 1);

    lane_state_t   state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          pulse_nxt;
    logic          held_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WAIT_REL;
            cnt   <= '0;
            pulse <= 1'b0;
            held  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            pulse <= pulse_nxt;
            held  <= held_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pulse_nxt = 1'b0;

        unique case (state)
            // Leaving reset with the button down must not count as a press.
            WAIT_REL: begin
                if (!btn_lvl) state_nxt = IDLE;
            end

            IDLE: begin
                if (btn_lvl) begin
                    state_nxt = HOLD;
                    cnt_nxt   = '0;
                    pulse_nxt = 1'b1;
                end
            end

            // Release is checked first so a release on the terminal-count
            // edge never emits a pulse.
            HOLD: begin
                if (!btn_lvl) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == HOLD_LAST) begin
                    if (repeat_en) begin
                        state_nxt = REPEAT;
                        cnt_nxt   = '0;
                        pulse_nxt = 1'b1;
                    end
                    // else: stay saturated until repeats are re-enabled
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end

            // Dropping repeat_en parks the lane in a saturated HOLD so that
            // re-enabling fires the next repeat on the following edge.
            REPEAT: begin
                if (!btn_lvl) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (!repeat_en) begin
                    state_nxt = HOLD;
                    cnt_nxt   = HOLD_LAST;
                end else if (cnt == REPEAT_LAST) begin
                    cnt_nxt   = '0;
                    pulse_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end

            default: begin
                state_nxt = WAIT_REL;
                cnt_nxt   = '0;
            end
        endcase

        held_nxt = (state_nxt == HOLD) || (state_nxt == REPEAT);
    end

endmodule : btn_pulse_lane

// File: rtl/btn_pulse_gen.sv
// -----------------------------------------------------------------------------
// btn_pulse_gen
// Bank of independent button lanes converting debounced levels into
// single-cycle press and auto-repeat command pulses.
// Ports:
//   clk        in  system clock
//   rst_n      in  asynchronous active-low reset
//   btn_lvl    in  [NUM_BTN] debounced levels (bit 0 = U, then L, R, D)
//   repeat_en  in  global auto-repeat enable shared by all lanes
//   btn_pulse  out [NUM_BTN] one-cycle press/repeat pulse per lane
//   btn_held   out [NUM_BTN] high while a lane is in HOLD or REPEAT
// -----------------------------------------------------------------------------
module btn_pulse_gen
    import btn_pkg::*;
#(
    parameter int NUM_BTN       = 4,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_lvl,
    input  logic               repeat_en,
    output logic [NUM_BTN-1:0] btn_pulse,
    output logic [NUM_BTN-1:0] btn_held
);

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_lane
        btn_pulse_lane #(
            .HOLD_CYCLES   (HOLD_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES)
        ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .btn_lvl   (btn_lvl[i]),
            .repeat_en (repeat_en),
            .pulse     (btn_pulse[i]),
            .held      (btn_held[i])
        );
    end

endmodule : btn_pulse_gen

// File: tb/tb_btn_pulse_gen.sv
// -----------------------------------------------------------------------------
// tb_btn_pulse_gen
// Directed bench for btn_pulse_gen with HOLD_CYCLES = 8, REPEAT_CYCLES = 4.
// Each step pushes the expected {btn_pulse, btn_held} for the coming edge and
// pops it for comparison 1 ns after that edge.
// -----------------------------------------------------------------------------
module tb_btn_pulse_gen;

    localparam int NB = 4;
    localparam int HC = 8;
    localparam int RC = 4;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [NB-1:0] btn_lvl;
    logic          repeat_en;
    logic [NB-1:0] btn_pulse;
    logic [NB-1:0] btn_held;

    btn_pulse_gen #(
        .NUM_BTN       (NB),
        .HOLD_CYCLES   (HC),
        .REPEAT_CYCLES (RC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_lvl   (btn_lvl),
        .repeat_en (repeat_en),
        .btn_pulse (btn_pulse),
        .btn_held  (btn_held)
    );

    // scoreboard
    logic [2*NB-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    task automatic compare(input string tag, input logic [2*NB-1:0] want);
        logic [2*NB-1:0] obs;
        obs = {btn_pulse, btn_held};
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s: pulse/held got %b/%b expected %b/%b",
                   tag, obs[2*NB-1:NB], obs[NB-1:0], want[2*NB-1:NB], want[NB-1:0]);
        end
    endtask

    // One clock edge with the inputs currently driven.
    task automatic step(input string tag, input logic [NB-1:0] ep, input logic [NB-1:0] eh);
        logic [2*NB-1:0] want;
        exp_q.push_back({ep, eh});
        @(posedge clk);
        #1;
        want = exp_q.pop_front();
        compare(tag, want);
    endtask

    // Compare right now, no clock edge.
    task automatic check_now(input string tag, input logic [NB-1:0] ep, input logic [NB-1:0] eh);
        exp_q.push_back({ep, eh});
        compare(tag, exp_q.pop_front());
    endtask

    // Pulse pattern of a held button with repeats enabled, k edges after press.
    function automatic logic rep_pulse(input int k);
        return (k == 0) || (k >= HC && ((k - HC) % RC) == 0);
    endfunction

    initial begin
        logic [NB-1:0] ep;
        logic [NB-1:0] eh;

        rst_n     = 1'b1;
        btn_lvl   = 4'b0001;
        repeat_en = 1'b1;
        #2 rst_n  = 1'b0;
        #1;
        check_now("reset_async", 4'b0000, 4'b0000);
        step("reset_clocked", 4'b0000, 4'b0000);
        step("reset_clocked2", 4'b0000, 4'b0000);
        rst_n = 1'b1;

        // S1: held through reset -> silent until release and re-press
        for (int k = 0; k < 5; k++) step("held_thru_reset", 4'b0000, 4'b0000);
        btn_lvl = 4'b0000;
        step("s1_release", 4'b0000, 4'b0000);
        btn_lvl = 4'b0001;
        step("s1_press", 4'b0001, 4'b0001);
        btn_lvl = 4'b0000;
        step("s1_after_press", 4'b0000, 4'b0000);
        step("s1_idle", 4'b0000, 4'b0000);

        // S2: lane 2 held 20 cycles with repeats: pulses at 0,8,12,16,20
        btn_lvl = 4'b0100;
        for (int k = 0; k <= 20; k++) begin
            ep = rep_pulse(k) ? 4'b0100 : 4'b0000;
            step("s2_repeat", ep, 4'b0100);
        end
        btn_lvl = 4'b0000;
        step("s2_release", 4'b0000, 4'b0000);

        // S3: repeats disabled, then enabled after edge N+12 -> pulses 13,17,21
        repeat_en = 1'b0;
        btn_lvl   = 4'b0100;
        for (int k = 0; k <= 12; k++) begin
            ep = (k == 0) ? 4'b0100 : 4'b0000;
            step("s3_no_repeat", ep, 4'b0100);
        end
        repeat_en = 1'b1;
        for (int k = 13; k <= 21; k++) begin
            ep = (k == 13 || k == 17 || k == 21) ? 4'b0100 : 4'b0000;
            step("s3_reenable", ep, 4'b0100);
        end
        btn_lvl = 4'b0000;
        step("s3_release", 4'b0000, 4'b0000);

        // S4: release on the terminal-count edge -> no pulse, then re-press
        btn_lvl = 4'b1000;
        for (int k = 0; k < HC; k++) begin
            ep = (k == 0) ? 4'b1000 : 4'b0000;
            step("s4_hold", ep, 4'b1000);
        end
        btn_lvl = 4'b0000;
        step("s4_release_at_tc", 4'b0000, 4'b0000);
        btn_lvl = 4'b1000;
        step("s4_repress", 4'b1000, 4'b1000);
        btn_lvl = 4'b0000;
        step("s4_release", 4'b0000, 4'b0000);

        // S5: all lanes together, lane 1 released after 3 edges
        btn_lvl = 4'b1111;
        for (int k = 0; k <= 16; k++) begin
            if (k == 3) btn_lvl = 4'b1101;
            ep = rep_pulse(k) ? 4'b1101 : 4'b0000;
            ep[1] = (k == 0);
            eh = (k < 3) ? 4'b1111 : 4'b1101;
            step("s5_multi", ep, eh);
        end
        btn_lvl = 4'b0000;
        step("s5_release", 4'b0000, 4'b0000);

        // S6: async reset while a repeat pulse is high
        btn_lvl = 4'b0001;
        for (int k = 0; k <= HC; k++) begin
            ep = rep_pulse(k) ? 4'b0001 : 4'b0000;
            step("s6_hold", ep, 4'b0001);
        end
        #2 rst_n = 1'b0;
        #1;
        check_now("s6_async_drop", 4'b0000, 4'b0000);
        step("s6_in_reset", 4'b0000, 4'b0000);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) step("s6_held_after_reset", 4'b0000, 4'b0000);
        btn_lvl = 4'b0000;
        step("s6_release", 4'b0000, 4'b0000);
        btn_lvl = 4'b0001;
        step("s6_repress", 4'b0001, 4'b0001);
        btn_lvl = 4'b0000;
        step("s6_final", 4'b0000, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_btn_pulse_gen
